// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch sequencer: FSM encoding, PC step
// and timeout counter width.
package ifetch_pkg;

  localparam int          CNT_W   = 8;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_REQ    = 2'd1;
  localparam state_t ST_UPDATE = 2'd2;
  localparam state_t ST_FAULT  = 2'd3;

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory req/ack bus between the fetch sequencer (master) and
// instruction memory (slave).
interface ifetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/ifetch_npc_sel.sv
// Next-PC selection: jump overrides branch, otherwise the sequential address
// (wraps modulo 2^32).
module npc_sel
  import ifetch_pkg::*;
(
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] fetch_addr_i,
  output logic [31:0] npc_o
);

  always_comb begin
    if (jump_i) begin
      npc_o = jump_target_i;
    end else if (branch_i) begin
      npc_o = branch_target_i;
    end else begin
      npc_o = fetch_addr_i + PC_STEP;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch sequencer: fetches at pc over the imem bus, then loads
// NextPC into the PC register. Optional fetch timeout: IFETCH_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for stall=0, checks pc alignment
// REQ    | imem_req held until imem_ack
// UPDATE | PC_enable / instr_valid pulse
// FAULT  | sticky error, left only through clr_n
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [31:0]      pc,
  input  logic             stall,
  input  logic             branch,
  input  logic             jump,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  ifetch_if.master         imem,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      NextPC,
  output logic             PC_enable,
  output logic             fault
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("ifetch: TIMEOUT must be within 1..255");
  end

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] npc_sel_w;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  npc_sel u_npc_sel (
    .jump_i          (jump),
    .branch_i        (branch),
    .jump_target_i   (jump_target),
    .branch_target_i (branch_target),
    .fetch_addr_i    (addr_q),
    .npc_o           (npc_sel_w)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    npc_d   = npc_q;
`ifdef IFETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!stall) begin
          if (pc[1:0] != 2'b00) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_REQ;
            addr_d  = pc;
`ifdef IFETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_REQ: begin
        // ack wins over a timeout reached on the same edge
        if (imem.imem_ack) begin
          state_d = ST_UPDATE;
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          npc_d   = npc_sel_w;
        end else begin
`ifdef IFETCH_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TMO_CNT) begin
            state_d = ST_FAULT;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      npc_q   <= RESET_VECTOR;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      npc_q   <= npc_d;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign imem.imem_req  = (state_q == ST_REQ);
  assign imem.imem_addr = addr_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign NextPC         = npc_q;
  assign PC_enable      = (state_q == ST_UPDATE);
  assign fault          = (state_q == ST_FAULT);

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: each fetch is predicted from the PC register,
// the redirect inputs on the ack edge and the wait-state count.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] pc;
  logic        stall;
  logic        branch;
  logic        jump;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] NextPC;
  logic        PC_enable;
  logic        fault;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] pc_model;

  ifetch_if imem_bus ();

  ifetch #(
    .RESET_VECTOR (32'h0000_0000),
    .TIMEOUT      (4)
  ) dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .pc            (pc),
    .stall         (stall),
    .branch        (branch),
    .jump          (jump),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .imem          (imem_bus),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .NextPC        (NextPC),
    .PC_enable     (PC_enable),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic redirect_noise();
    branch        = 1'($urandom_range(0, 1));
    jump          = 1'($urandom_range(0, 1));
    branch_target = $urandom();
    jump_target   = $urandom();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},   {31'b0, imem_bus.imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_bus.imem_addr, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_npc"},   NextPC, 32'd0);
    chk({tag, "_pe"},    {31'b0, PC_enable}, 32'd0);
    chk({tag, "_fault"}, {31'b0, fault}, 32'd0);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    stall = 1'b1;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    branch = 1'b0;
    jump   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    clr_n    = 1'b1;
    pc_model = 32'd0;
    pc       = 32'd0;
  endtask

  // Entry: DUT idle with stall=1, at a negedge. Exit: same, PC model advanced.
  task automatic do_fetch(input logic [31:0] p, input int waits,
                          input logic br, input logic jp,
                          input logic [31:0] bt, input logic [31:0] jt,
                          input logic [31:0] rd);
    logic [31:0] exp_npc;
    exp_npc = jp ? jt : (br ? bt : p + 32'd4);
    pc    = p;
    stall = 1'b0;
    imem_bus.imem_ack = 1'b0;
    redirect_noise();
    @(negedge clk);
    chk("req_first", {31'b0, imem_bus.imem_req}, 32'd1);
    chk("addr_first", imem_bus.imem_addr, p);
    for (int i = 0; i < waits; i++) begin
      stall = 1'($urandom_range(0, 1));
      redirect_noise();
      @(negedge clk);
      chk("req_wait", {31'b0, imem_bus.imem_req}, 32'd1);
      chk("addr_wait", imem_bus.imem_addr, p);
      chk("fault_wait", {31'b0, fault}, 32'd0);
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = rd;
    branch = br;
    jump   = jp;
    branch_target = bt;
    jump_target   = jt;
    stall = 1'($urandom_range(0, 1));
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = $urandom();
    redirect_noise();
    chk("upd_pe", {31'b0, PC_enable}, 32'd1);
    chk("upd_valid", {31'b0, instr_valid}, 32'd1);
    chk("upd_instr", instr, rd);
    chk("upd_npc", NextPC, exp_npc);
    chk("upd_req", {31'b0, imem_bus.imem_req}, 32'd0);
    stall = 1'b1;
    @(negedge clk);
    pc_model = exp_npc;
    pc       = pc_model;
    chk("idle_pe", {31'b0, PC_enable}, 32'd0);
    chk("idle_valid", {31'b0, instr_valid}, 32'd0);
    chk("idle_instr", instr, rd);
    chk("idle_npc", NextPC, exp_npc);
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      chk("stall_req", {31'b0, imem_bus.imem_req}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] p;
    pc = 32'd0;
    stall = 1'b1;
    branch_target = 32'd0;
    jump_target   = 32'd0;
    do_reset();

    // sequential fetch, zero wait
    do_fetch(32'd0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h2008_0005);
    // jump beats branch
    do_fetch(32'd8, 1, 1'b1, 1'b1, 32'h40, 32'h100, $urandom());
    // three wait states with stall toggling
    do_fetch(pc_model, 3, 1'b0, 1'b0, 32'd0, 32'd0, $urandom());
    // branch only
    do_fetch(pc_model, 0, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, $urandom());
    // wrap
    do_fetch(32'hFFFF_FFFC, 2, 1'b0, 1'b0, 32'd0, 32'd0, $urandom());
    chk("wrap_pc", pc_model, 32'd0);

    for (int k = 0; k < 40; k++) begin
      do_fetch(pc_model, $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC, $urandom());
    end

    // misaligned pc
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? 32'h0000_0006 : (($urandom() & 32'hFFFF_FFFC) | 32'd1);
      pc = p;
      stall = 1'b0;
      @(negedge clk);
      chk("mis_fault", {31'b0, fault}, 32'd1);
      chk("mis_req", {31'b0, imem_bus.imem_req}, 32'd0);
      repeat (5) begin
        stall = 1'($urandom_range(0, 1));
        pc = $urandom() & 32'hFFFF_FFFC;
        @(negedge clk);
        chk("mis_sticky", {31'b0, fault}, 32'd1);
        chk("mis_req_low", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("mis_pe_low", {31'b0, PC_enable}, 32'd0);
      end
      do_reset();
    end

`ifdef IFETCH_TIMEOUT_EN
    // no ack: fault after the 4th REQ edge
    pc = 32'h0000_0040;
    stall = 1'b0;
    imem_bus.imem_ack = 1'b0;
    @(negedge clk);
    chk("tmo_req", {31'b0, imem_bus.imem_req}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("tmo_fault", {31'b0, fault}, (i == 4) ? 32'd1 : 32'd0);
      chk("tmo_req_i", {31'b0, imem_bus.imem_req}, (i == 4) ? 32'd0 : 32'd1);
    end
    do_reset();
    // ack on the 4th REQ cycle still completes
    do_fetch(32'h0000_0080, 3, 1'b0, 1'b0, 32'd0, 32'd0, $urandom());
    chk("tmo_ack_fault", {31'b0, fault}, 32'd0);
`else
    do_fetch(32'h0000_0080, 20, 1'b0, 1'b0, 32'd0, 32'd0, $urandom());
    chk("long_wait_fault", {31'b0, fault}, 32'd0);
`endif

    // asynchronous reset in the middle of REQ, with an ack arriving during reset
    pc = 32'h0000_0100;
    stall = 1'b0;
    @(negedge clk);
    chk("mid_req", {31'b0, imem_bus.imem_req}, 32'd1);
    #2;
    clr_n = 1'b0;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk_reset_outs("mid_async");
    @(negedge clk);
    chk_reset_outs("mid_hold");
    imem_bus.imem_ack = 1'b0;
    stall = 1'b1;
    clr_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    chk("post_rst_instr", instr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
